uart_tx_ctrl: RTL and testbench

//  Frame sequencer for the UART transmitter. Accepts a byte from the upstream side
//  and issues load/shift controls to the 8-bit LSB-first serializer. Computes parity
//  and drives the TX line through start/data/parity/stop. One CLK = one bit period.

---
 rtl/uart_tx_ctrl_if.sv | 30 +++
 rtl/uart_tx_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_ctrl_if.sv
// Bundle of upstream request, serializer handshake and line-side signals for
// the UART transmit frame sequencer. The master side is the environment
// (upstream requester plus serializer); the slave side is uart_tx_ctrl.
interface uart_tx_ctrl_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] P_DATA;
  logic              Data_Valid;
  logic              PAR_EN;
  logic              PAR_TYP;
  logic              ser_done;
  logic              ser_data;
  logic              ser_load;
  logic [DATA_W-1:0] ser_pdata;
  logic              ser_en;
  logic              TX_OUT;
  logic              Busy;
  logic              ser_err;
  logic              Hold_Full;

  modport master (
    output P_DATA, Data_Valid, PAR_EN, PAR_TYP, ser_done, ser_data,
    input  ser_load, ser_pdata, ser_en, TX_OUT, Busy, ser_err, Hold_Full
  );

  modport slave (
    input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, ser_done, ser_data,
    output ser_load, ser_pdata, ser_en, TX_OUT, Busy, ser_err, Hold_Full
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start / DATA_W data bits / optional parity /
// STOP_BITS stop bits, one bit per CLK. Drives load/shift controls of an
// LSB-first serializer and flags (sticky) a ser_done seen on the wrong cycle.
// Optional one-entry holding buffer enabled by defining UART_TX_HOLD_BUF_EN.
module uart_tx_ctrl #(
  parameter int DATA_W    = 8,
  parameter int STOP_BITS = 1
) (
  input  logic           CLK,
  input  logic           RST,
  uart_tx_ctrl_if.slave  bus
);
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              par_en_q, par_en_d;
  logic              par_typ_q, par_typ_d;
  logic              err_q, err_d;
  logic              last_stop;
  logic              busy;
  logic              accept_direct;
  logic              take_next;

`ifdef UART_TX_HOLD_BUF_EN
  logic              hold_full_q, hold_full_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic              hold_pe_q, hold_pe_d;
  logic              hold_pt_q, hold_pt_d;
`endif

  function automatic logic parity_bit(input logic [DATA_W-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  assign last_stop = (state_q == S_STOP) && (cnt_q == LAST_STOP);
  assign busy      = (state_q != S_IDLE) && !last_stop;

`ifdef UART_TX_HOLD_BUF_EN
  // A buffered request has priority over a new one on the final stop cycle.
  assign accept_direct = bus.Data_Valid && ((state_q == S_IDLE) || (last_stop && !hold_full_q));
  assign take_next     = hold_full_q || bus.Data_Valid;
`else
  assign accept_direct = bus.Data_Valid && ((state_q == S_IDLE) || last_stop);
  assign take_next     = bus.Data_Valid;
`endif

  // State register and all flops; async reset aborts any frame in progress.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      data_q      <= '0;
      par_en_q    <= 1'b0;
      par_typ_q   <= 1'b0;
      err_q       <= 1'b0;
`ifdef UART_TX_HOLD_BUF_EN
      hold_full_q <= 1'b0;
      hold_data_q <= '0;
      hold_pe_q   <= 1'b0;
      hold_pt_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      par_en_q    <= par_en_d;
      par_typ_q   <= par_typ_d;
      err_q       <= err_d;
`ifdef UART_TX_HOLD_BUF_EN
      hold_full_q <= hold_full_d;
      hold_data_q <= hold_data_d;
      hold_pe_q   <= hold_pe_d;
      hold_pt_q   <= hold_pt_d;
`endif
    end
  end

  // Next-state and bit counter; DATA length is set by the counter only.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE:   if (bus.Data_Valid) state_d = S_START;
      S_START: begin
        state_d = S_DATA;
        cnt_d   = '0;
      end
      S_DATA: begin
        if (cnt_q == LAST_DATA) begin
          cnt_d   = '0;
          state_d = par_en_q ? S_PARITY : S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PARITY: begin
        state_d = S_STOP;
        cnt_d   = '0;
      end
      S_STOP: begin
        if (cnt_q == LAST_STOP) begin
          cnt_d   = '0;
          state_d = take_next ? S_START : S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Request capture (frame registers, holding buffer) and sticky ser_done check.
  always_comb begin
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    err_d     = err_q;
    if (state_q == S_DATA) begin
      if (cnt_q == LAST_DATA) err_d = err_q | ~bus.ser_done;
      else                    err_d = err_q | bus.ser_done;
    end
`ifdef UART_TX_HOLD_BUF_EN
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    hold_pe_d   = hold_pe_q;
    hold_pt_d   = hold_pt_q;
    if (last_stop && hold_full_q) begin
      data_d      = hold_data_q;
      par_en_d    = hold_pe_q;
      par_typ_d   = hold_pt_q;
      hold_full_d = bus.Data_Valid;
      if (bus.Data_Valid) begin
        hold_data_d = bus.P_DATA;
        hold_pe_d   = bus.PAR_EN;
        hold_pt_d   = bus.PAR_TYP;
      end
    end else if (accept_direct) begin
      data_d    = bus.P_DATA;
      par_en_d  = bus.PAR_EN;
      par_typ_d = bus.PAR_TYP;
    end else if (busy && !hold_full_q && bus.Data_Valid) begin
      hold_full_d = 1'b1;
      hold_data_d = bus.P_DATA;
      hold_pe_d   = bus.PAR_EN;
      hold_pt_d   = bus.PAR_TYP;
    end
`else
    if (accept_direct) begin
      data_d    = bus.P_DATA;
      par_en_d  = bus.PAR_EN;
      par_typ_d = bus.PAR_TYP;
    end
`endif
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    bus.TX_OUT   = 1'b1;
    bus.Busy     = busy;
    bus.ser_load = 1'b0;
    bus.ser_en   = 1'b0;
    unique case (state_q)
      S_START: begin
        bus.TX_OUT   = 1'b0;
        bus.ser_load = 1'b1;
      end
      S_DATA: begin
        bus.TX_OUT = bus.ser_data;
        bus.ser_en = 1'b1;
      end
      S_PARITY: bus.TX_OUT = parity_bit(data_q, par_typ_q);
      default:  bus.TX_OUT = 1'b1;
    endcase
    bus.ser_pdata = data_q;
    bus.ser_err   = err_q;
`ifdef UART_TX_HOLD_BUF_EN
    bus.Hold_Full = hold_full_q;
`else
    bus.Hold_Full = 1'b0;
`endif
  end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed testbench for uart_tx_ctrl: frame table plus hand-written
// back-to-back, reset-abort, ser_done error and holding-buffer sequences.
module tb_uart_tx_ctrl;
  logic CLK = 1'b0;
  logic RST = 1'b1;

  uart_tx_ctrl_if #(.DATA_W(8)) bus ();

  uart_tx_ctrl #(.DATA_W(8), .STOP_BITS(1)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  always #5 CLK = ~CLK;

  // Serializer model: 0 = done on 8th shift, 1 = one cycle early, 2 = never.
  logic [7:0] sreg = 8'hFF;
  int         scnt = 0;
  int         ser_mode = 0;

  always @(posedge CLK) begin
    if (bus.ser_load) begin
      sreg <= bus.ser_pdata;
      scnt <= 0;
    end else if (bus.ser_en) begin
      sreg <= sreg >> 1;
      scnt <= scnt + 1;
    end
  end

  assign bus.ser_data = sreg[0];
  assign bus.ser_done = bus.ser_en && ((ser_mode == 0 && scnt == 7) || (ser_mode == 1 && scnt == 6));

  typedef struct {
    logic [7:0]  data;
    logic        pe;
    logic        pt;
    logic [0:11] tx;    // TX_OUT per cycle from start bit, send order left to right
    logic [0:11] busy;  // Busy per cycle
  } vec_t;

  vec_t vecs[7];
  vec_t v33;

  logic [0:20] e3_tx   = 21'b0111100001_0000011111_1;
  logic [0:21] e6_tx   = 22'b0100010001_0010001001_11;
  logic [0:21] e6_hf   = 22'b0111111111_000000000000;
  logic [0:21] e6_busy = 22'b1111111110_1111111110_00;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Sends one frame from idle and checks 12 cycles starting at the start bit.
  task automatic run_frame(input vec_t v, input string tag);
    bus.P_DATA     = v.data;
    bus.PAR_EN     = v.pe;
    bus.PAR_TYP    = v.pt;
    bus.Data_Valid = 1'b1;
    @(posedge CLK);
    #1;
    bus.Data_Valid = 1'b0;
    bus.PAR_EN     = ~v.pe;
    bus.PAR_TYP    = ~v.pt;
    bus.P_DATA     = ~v.data;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      chk1($sformatf("%s tx[%0d]", tag, i), bus.TX_OUT, v.tx[i]);
      chk1($sformatf("%s busy[%0d]", tag, i), bus.Busy, v.busy[i]);
      chk1($sformatf("%s load[%0d]", tag, i), bus.ser_load, (i == 0));
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    vecs[0] = '{8'h55, 1'b0, 1'b0, 12'b010101010111, 12'b111111111000};
    vecs[1] = '{8'hA5, 1'b1, 1'b0, 12'b010100101011, 12'b111111111100};
    vecs[2] = '{8'hA5, 1'b1, 1'b1, 12'b010100101111, 12'b111111111100};
    vecs[3] = '{8'h0F, 1'b0, 1'b0, 12'b011110000111, 12'b111111111000};
    vecs[4] = '{8'hF0, 1'b0, 1'b1, 12'b000001111111, 12'b111111111000};
    vecs[5] = '{8'h01, 1'b1, 1'b1, 12'b010000000011, 12'b111111111100};
    vecs[6] = '{8'h00, 1'b1, 1'b0, 12'b000000000011, 12'b111111111100};
    v33     = '{8'h33, 1'b0, 1'b0, 12'b011001100111, 12'b111111111000};

    bus.P_DATA     = 8'h00;
    bus.Data_Valid = 1'b0;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = 1'b0;

    // Reset state
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk1("rst TX_OUT", bus.TX_OUT, 1'b1);
    chk1("rst Busy", bus.Busy, 1'b0);
    chk1("rst ser_load", bus.ser_load, 1'b0);
    chk1("rst ser_en", bus.ser_en, 1'b0);
    chk1("rst ser_err", bus.ser_err, 1'b0);
    chk1("rst Hold_Full", bus.Hold_Full, 1'b0);
    chk8("rst ser_pdata", bus.ser_pdata, 8'h00);
    @(posedge CLK);
    #1 RST = 1'b0;
    @(posedge CLK);
    #1;

    // Frame table
    for (int k = 0; k < 7; k++) begin
      run_frame(vecs[k], $sformatf("vec%0d", k));
      chk1($sformatf("vec%0d ser_err", k), bus.ser_err, 1'b0);
    end

`ifdef UART_TX_HOLD_BUF_EN
    // Holding buffer: 2nd request back-to-back, 3rd dropped
    bus.P_DATA     = 8'h11;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = 1'b0;
    bus.Data_Valid = 1'b1;
    @(posedge CLK);
    #1 bus.P_DATA = 8'h22;
    for (int i = 0; i < 22; i++) begin
      @(negedge CLK);
      chk1($sformatf("hold tx[%0d]", i), bus.TX_OUT, e6_tx[i]);
      chk1($sformatf("hold full[%0d]", i), bus.Hold_Full, e6_hf[i]);
      chk1($sformatf("hold busy[%0d]", i), bus.Busy, e6_busy[i]);
      @(posedge CLK);
      #1;
      if (i == 0) bus.Data_Valid = 1'b0;
      if (i == 2) begin
        bus.P_DATA     = 8'h33;
        bus.Data_Valid = 1'b1;
      end
      if (i == 3) bus.Data_Valid = 1'b0;
    end
`else
    // Data_Valid held across two frames: no idle gap between them
    bus.P_DATA     = 8'h0F;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = 1'b0;
    bus.Data_Valid = 1'b1;
    @(posedge CLK);
    #1 bus.P_DATA = 8'hF0;
    for (int i = 0; i < 21; i++) begin
      @(negedge CLK);
      chk1($sformatf("b2b tx[%0d]", i), bus.TX_OUT, e3_tx[i]);
      chk1($sformatf("b2b hold[%0d]", i), bus.Hold_Full, 1'b0);
      if (i == 9) chk1("b2b busy final stop", bus.Busy, 1'b0);
      if (i == 10) begin
        chk1("b2b busy 2nd start", bus.Busy, 1'b1);
        chk1("b2b load 2nd start", bus.ser_load, 1'b1);
        chk8("b2b pdata 2nd", bus.ser_pdata, 8'hF0);
      end
      @(posedge CLK);
      #1;
      if (i == 9) bus.Data_Valid = 1'b0;
    end
`endif

    // Reset in the 4th DATA cycle aborts at once
    bus.P_DATA     = 8'hA5;
    bus.PAR_EN     = 1'b0;
    bus.Data_Valid = 1'b1;
    @(posedge CLK);
    #1 bus.Data_Valid = 1'b0;
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    chk1("abort pre tx", bus.TX_OUT, 1'b0);
    chk1("abort pre busy", bus.Busy, 1'b1);
    RST = 1'b1;
    #1;
    chk1("abort tx", bus.TX_OUT, 1'b1);
    chk1("abort busy", bus.Busy, 1'b0);
    chk1("abort ser_en", bus.ser_en, 1'b0);
    @(posedge CLK);
    #1;
    chk1("abort held tx", bus.TX_OUT, 1'b1);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    run_frame(v33, "after_abort");
    chk1("after_abort ser_err", bus.ser_err, 1'b0);

    // ser_done one cycle early: error set, timing unchanged, sticky
    ser_mode = 1;
    run_frame(vecs[0], "early");
    chk1("early ser_err", bus.ser_err, 1'b1);
    ser_mode = 0;
    run_frame(vecs[3], "sticky");
    chk1("sticky ser_err", bus.ser_err, 1'b1);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    chk1("err cleared by rst", bus.ser_err, 1'b0);
    RST = 1'b0;
    @(posedge CLK);
    #1;

    // ser_done never arrives
    ser_mode = 2;
    run_frame(vecs[1], "never");
    chk1("never ser_err", bus.ser_err, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
